// File: rtl/uart_cmd_slave.sv
// UART command responder: decodes write/read command frames on rx, drives a register port, replies on tx.
// Optional feature macro UART_SLV_ERRCNT_EN adds a saturating error counter, readable at address 0x7F.
module uart_cmd_slave #(
    parameter int BR           = 434,
    parameter int ADDR_WIDTH   = 7,
    parameter int TURN_BITS    = 2,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic                  tx,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic                  reg_wr_en,
    output logic [7:0]            reg_wdata,
    output logic                  reg_rd_en,
    input  logic [7:0]            reg_rdata,
    output logic                  busy,
    output logic                  err_parity,
`ifdef UART_SLV_ERRCNT_EN
    output logic [7:0]            err_cnt,
`endif
    output logic                  err_frame
);

    localparam int CW        = (BR > 1) ? $clog2(BR) : 1;
    localparam int TURN_CLKS = TURN_BITS * BR;
    localparam int TO_CLKS   = TIMEOUT_BITS * BR;
    localparam int TMAX      = (TO_CLKS > TURN_CLKS) ? TO_CLKS : TURN_CLKS;
    localparam int TW        = $clog2(TMAX + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(BR - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(BR / 2);
    // Turnaround ends 3 clocks early: DECODE, REG_READ and the tx register edge fill the gap.
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CLKS - 3);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_CLKS - 1);
    localparam logic [TW-1:0] TCNT_MAX  = TW'(TMAX);

    typedef enum logic [3:0] {
        IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, DECODE, WAIT_DATA,
        REG_WRITE, REG_READ, TURNAROUND, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } state_t;

    state_t          state;
    logic            rx_meta, rx_sync, rx_prev;
    logic [CW-1:0]   cnt;
    logic [3:0]      bit_idx;
    logic [TW-1:0]   tcnt;
    logic [7:0]      rx_shift;
    logic            rx_par, rx_stop;
    logic            byte_idx;
    logic [7:0]      tx_shift;
    logic            tx_par;
    logic [7:0]      tx_load;
    logic            errcnt_hit;

    wire             fall     = rx_prev & ~rx_sync;
    wire             cnt_wrap = (cnt == CNT_LAST);
    wire             cnt_mid  = (cnt == CNT_MID);
    wire [CW-1:0]    cnt_inc  = cnt_wrap ? '0 : cnt + CW'(1);
    wire [TW-1:0]    tcnt_inc = (tcnt == TCNT_MAX) ? tcnt : tcnt + TW'(1);
    wire             par_bad  = (^rx_shift) ^ rx_par;

    assign busy = (state != IDLE);

`ifdef UART_SLV_ERRCNT_EN
    logic rd_errcnt;
    assign errcnt_hit = (rx_shift[6:0] == 7'h7F);
    assign tx_load    = rd_errcnt ? err_cnt : reg_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt   <= 8'h00;
            rd_errcnt <= 1'b0;
        end else begin
            if (state == DECODE)
                rd_errcnt <= errcnt_hit;
            if ((err_parity || err_frame) && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'h01;
        end
    end
`else
    assign errcnt_hit = 1'b0;
    assign tx_load    = reg_rdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            reg_addr   <= '0;
            reg_wdata  <= 8'h00;
            reg_wr_en  <= 1'b0;
            reg_rd_en  <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            cnt        <= '0;
            bit_idx    <= 4'd0;
            tcnt       <= '0;
            rx_shift   <= 8'h00;
            rx_par     <= 1'b0;
            rx_stop    <= 1'b1;
            byte_idx   <= 1'b0;
            tx_shift   <= 8'h00;
            tx_par     <= 1'b0;
        end else begin
            reg_wr_en  <= 1'b0;
            reg_rd_en  <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        cnt   <= CW'(1);
                        state <= RX_START;
                    end
                end
                WAIT_DATA: begin
                    if (fall) begin
                        cnt   <= CW'(1);
                        state <= RX_START;
                    end else if (tcnt == TO_LAST) begin
                        err_frame <= 1'b1;
                        byte_idx  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                RX_START: begin
                    cnt <= cnt_inc;
                    if (cnt_mid) begin
                        bit_idx <= 4'd0;
                        state   <= rx_sync ? (byte_idx ? WAIT_DATA : IDLE) : RX_DATA;
                    end
                end
                RX_DATA: begin
                    cnt <= cnt_inc;
                    if (cnt_mid) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 4'd1;
                        if (bit_idx == 4'd7)
                            state <= RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    cnt <= cnt_inc;
                    if (cnt_mid) begin
                        rx_par <= rx_sync;
                        state  <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    cnt <= cnt_inc;
                    if (cnt_mid) begin
                        rx_stop <= rx_sync;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (par_bad || !rx_stop) begin
                        err_parity <= par_bad;
                        err_frame  <= ~rx_stop;
                        byte_idx   <= 1'b0;
                        state      <= IDLE;
                    end else if (byte_idx) begin
                        reg_wdata <= rx_shift;
                        reg_wr_en <= 1'b1;
                        byte_idx  <= 1'b0;
                        state     <= REG_WRITE;
                    end else if (rx_shift[7]) begin
                        reg_addr <= rx_shift[ADDR_WIDTH-1:0];
                        byte_idx <= 1'b1;
                        tcnt     <= '0;
                        state    <= WAIT_DATA;
                    end else begin
                        reg_addr  <= rx_shift[ADDR_WIDTH-1:0];
                        reg_rd_en <= ~errcnt_hit;
                        state     <= REG_READ;
                    end
                end
                REG_WRITE: state <= IDLE;
                REG_READ: begin
                    tcnt  <= '0;
                    state <= TURNAROUND;
                end
                TURNAROUND: begin
                    // Register block presents read data one cycle after the strobe.
                    if (tcnt == '0) begin
                        tx_shift <= tx_load;
                        tx_par   <= ^tx_load;
                    end
                    if (tcnt == TURN_LAST) begin
                        tx    <= 1'b0;
                        cnt   <= '0;
                        state <= TX_START;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                TX_START: begin
                    cnt <= cnt_inc;
                    if (cnt_wrap) begin
                        tx       <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        bit_idx  <= 4'd0;
                        state    <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    cnt <= cnt_inc;
                    if (cnt_wrap) begin
                        if (bit_idx == 4'd7) begin
                            tx    <= tx_par;
                            state <= TX_PARITY;
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            bit_idx  <= bit_idx + 4'd1;
                        end
                    end
                end
                TX_PARITY: begin
                    cnt <= cnt_inc;
                    if (cnt_wrap) begin
                        tx    <= 1'b1;
                        state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    cnt <= cnt_inc;
                    if (cnt_wrap)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Randomized bench for uart_cmd_slave: serial stimulus against a register-map reference model.
module tb_uart_cmd_slave;
    localparam int BR           = 16;
    localparam int TURN_BITS    = 2;
    localparam int TIMEOUT_BITS = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       tx;
    logic [6:0] reg_addr;
    logic       reg_wr_en;
    logic [7:0] reg_wdata;
    logic       reg_rd_en;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy, err_parity, err_frame;
`ifdef UART_SLV_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    uart_cmd_slave #(.BR(BR), .ADDR_WIDTH(7), .TURN_BITS(TURN_BITS), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx),
        .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata),
        .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata), .busy(busy),
        .err_parity(err_parity),
`ifdef UART_SLV_ERRCNT_EN
        .err_cnt(err_cnt),
`endif
        .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt = 0, rd_cnt = 0, perr_cnt = 0, ferr_cnt = 0, tx_low_cnt = 0;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] exp_mem [128];
    logic [7:0] mem [128];
    bit         mem_ready = 1'b0;

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] v;
        v = 8'(i * 29);
        return v ^ 8'h5A;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Register block emulation: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else begin
            if (reg_wr_en) mem[reg_addr] <= reg_wdata;
            if (reg_rd_en) reg_rdata <= mem[reg_addr];
        end
    end

    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_cnt++;
            wr_addr = reg_addr;
            wr_data = reg_wdata;
        end
        if (reg_rd_en) rd_cnt++;
        if (err_parity) perr_cnt++;
        if (err_frame) ferr_cnt++;
        if (!tx) tx_low_cnt++;
    end

    task automatic bit_out(input logic v);
        @(negedge clk);
        rx = v;
        repeat (BR - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit full);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out((^b) ^ flip_par);
        if (full) bit_out(1'b1);
        else begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_eq("busy_idle", busy, 0);
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [7:0] data, input bit bad);
        int wr0, pe0, tl0;
        wr0 = wr_cnt; pe0 = perr_cnt; tl0 = tx_low_cnt;
        send_frame({1'b1, addr}, 1'b0, 1'b1);
        send_frame(data, bad, 1'b1);
        repeat (4) @(negedge clk);
        wait_idle();
        repeat (2) @(negedge clk);
        if (bad) begin
            check_eq("wr_bad_perr", perr_cnt, pe0 + 1);
            check_eq("wr_bad_nowrite", wr_cnt, wr0);
        end else begin
            check_eq("wr_pulses", wr_cnt, wr0 + 1);
            check_eq("wr_addr", wr_addr, addr);
            check_eq("wr_data", wr_data, data);
            exp_mem[addr] = data;
        end
        check_eq("wr_tx_idle", tx_low_cnt, tl0);
        $display("txn WR addr=%02h data=%02h parity_err=%0d", addr, data, bad);
    endtask

    task automatic do_read(input logic [6:0] addr);
        int         rd0, lat;
        bit         seen;
        logic [7:0] got;
        rd0 = rd_cnt; seen = 1'b0; got = 8'h00;
        send_frame({1'b0, addr}, 1'b0, 1'b0);
        for (int n = 0; n < 4 * BR; n++) begin
            @(negedge clk);
            if (reg_rd_en) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("rd_en_seen", seen, 1);
        if (seen) begin
            check_eq("rd_addr", reg_addr, addr);
            lat = 1;
            while (lat <= 8 * BR) begin
                @(negedge clk);
                if (!tx) break;
                lat++;
            end
            check_eq("turn_latency", lat, TURN_BITS * BR - 1);
            repeat (BR / 2) @(negedge clk);
            check_eq("tx_start", tx, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (BR) @(negedge clk);
                got[i] = tx;
            end
            repeat (BR) @(negedge clk);
            check_eq("tx_parity", tx, ^exp_mem[addr]);
            repeat (BR) @(negedge clk);
            check_eq("tx_stop", tx, 1);
            check_eq("tx_data", got, exp_mem[addr]);
        end
        wait_idle();
        check_eq("rd_pulses", rd_cnt, rd0 + 1);
        $display("txn RD addr=%02h reply=%02h expected=%02h", addr, got, exp_mem[addr]);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_tx"}, tx, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_addr"}, reg_addr, 0);
        check_eq({tag, "_wdata"}, reg_wdata, 0);
        check_eq({tag, "_wr_en"}, reg_wr_en, 0);
        check_eq({tag, "_rd_en"}, reg_rd_en, 0);
        check_eq({tag, "_errs"}, {err_parity, err_frame}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pe0, fe0, wr0, rd0, lat;
        logic [6:0] a;
        logic [7:0] d;
        for (int i = 0; i < 128; i++) exp_mem[i] = init_val(i);

        repeat (4) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        do_write(7'h05, 8'h3C, 1'b0);
        do_read(7'h05);
        do_write(7'h05, 8'hA5, 1'b0);
        do_read(7'h05);

        pe0 = perr_cnt; wr0 = wr_cnt;
        send_frame(8'h85, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("perr_pulse", perr_cnt, pe0 + 1);
        check_eq("perr_nowrite", wr_cnt, wr0);
        check_eq("perr_idle", busy, 0);
        $display("txn bad-parity address frame 0x85");

        pe0 = perr_cnt; fe0 = ferr_cnt; wr0 = wr_cnt; rd0 = rd_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (BR) @(negedge clk);
        check_eq("glitch_idle", busy, 0);
        check_eq("glitch_noerr", perr_cnt + ferr_cnt, pe0 + fe0);
        check_eq("glitch_noacc", wr_cnt + rd_cnt, wr0 + rd0);
        $display("txn 4-clock rx glitch");

        fe0 = ferr_cnt; wr0 = wr_cnt;
        send_frame(8'h85, 1'b0, 1'b1);
        repeat (17 * BR) @(negedge clk);
        check_eq("timeout_ferr", ferr_cnt, fe0 + 1);
        check_eq("timeout_nowrite", wr_cnt, wr0);
        check_eq("timeout_idle", busy, 0);
        $display("txn write address 0x85 then timeout");
        do_read(7'h05);

        send_frame(8'h05, 1'b0, 1'b0);
        lat = 0;
        while (tx && lat < 8 * BR) begin
            @(negedge clk);
            lat++;
        end
        check_eq("rst_tx_started", tx, 0);
        repeat (BR + 3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_tx", tx, 1);
        check_eq("rst_async_busy", busy, 0);
        repeat (2) @(negedge clk);
        check_reset_state("midtx_reset");
        rst_n = 1'b1;
        $display("txn reset during reply");
        repeat (2) @(negedge clk);
        do_write(7'h22, 8'h99, 1'b0);
        do_read(7'h22);

        for (int t = 0; t < 24; t++) begin
            a = 7'($urandom_range(0, 127));
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1)
                do_write(a, d, $urandom_range(0, 7) == 0);
            else
                do_read(a);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_slave.md
Name: uart_cmd_slave

Overview:
- UART command responder. It is the far-end peer of the team's UART command master.
- Receives command frames on rx, decodes write or read, and drives a simple register port.
- For reads, it returns one data frame on tx after a fixed turnaround.
- Sits between the serial link and a local register block. Half-duplex.

Parameters:
BR, 434, clocks per bit period (min 8)
ADDR_WIDTH, 7, register address width (fixed 7, bits [6:0] of first byte)
TURN_BITS, 2, idle bit periods between end of read command stop bit and reply start bit
TIMEOUT_BITS, 16, max idle bit periods between write address byte stop and data byte start

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial in, idle high, asynchronous to clk
tx  output  1  serial out, idle high
reg_addr  output  7  register address
reg_wr_en  output  1  one-cycle write strobe
reg_wdata  output  8  write data, valid with reg_wr_en
reg_rd_en  output  1  one-cycle read strobe
reg_rdata  input  8  read data, valid the cycle after reg_rd_en
busy  output  1  high whenever FSM not in IDLE
err_parity  output  1  one-cycle pulse on parity mismatch
err_frame  output  1  one-cycle pulse on stop bit = 0 or inter-byte timeout

Behaviour:
- Reset values: tx=1; reg_addr=0; reg_wdata=0; reg_wr_en=0; reg_rd_en=0; busy=0; err_*=0. Async reset mid-frame forces tx=1 and state IDLE immediately.
- rx synchronisation: rx passes through a 2-flop synchroniser. All timing below is relative to the synchronised signal.
- Frame format: start(0), 8 data bits LSB first, even parity bit, stop(1). Each bit lasts BR clocks.
- Sampling: the bit counter starts on the falling edge seen in IDLE or WAIT_DATA. Each bit is sampled at count BR/2 (integer division).
- False start: if the start bit sampled at mid-bit is 1, the frame is discarded, the FSM returns to the prior waiting state, and no error is flagged.
- First byte: bit7=1 means write; bit7=0 means read. Bits[6:0] are the address.
- Write transaction: address byte, then data byte.
  - reg_wr_en pulses exactly one cycle, 1 clock after the data byte stop-bit sample, with reg_addr/reg_wdata valid.
  - reg_addr holds until the next transaction.
- Read transaction: address byte only.
  - reg_rd_en pulses 1 clock after the stop-bit sample; reg_rdata is captured on the next clock.
  - The TX start bit begins TURN_BITS*BR clocks after the stop-bit sample point.
  - The reply frame uses the same format. tx returns to 1 after the full stop bit; then back to IDLE.
- States: IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, DECODE, WAIT_DATA, REG_WRITE, REG_READ, TURNAROUND, TX_START, TX_DATA, TX_PARITY, TX_STOP.
- Byte tracking: an internal byte_idx flag distinguishes address vs data byte through the shared RX states.
- Transitions:
  - IDLE→RX_START on falling edge.
  - RX_START→RX_DATA after the start bit (→IDLE/WAIT_DATA on false start).
  - RX_DATA→RX_PARITY after 8 bits, then →RX_STOP, then →DECODE.
  - DECODE→WAIT_DATA (write address byte), →REG_WRITE (write data byte), or →REG_READ (read).
  - REG_WRITE→IDLE.
  - REG_READ→TURNAROUND→TX_START→TX_DATA(8)→TX_PARITY→TX_STOP→IDLE.
- Errors: a parity mismatch or stop=0 on either byte causes an err pulse in DECODE, no register access, and return to IDLE.
- Timeout: in WAIT_DATA, if no start edge arrives within TIMEOUT_BITS*BR clocks, err_frame pulses and the FSM returns to IDLE without writing.
- Half-duplex: rx is ignored from REG_READ through TX_STOP. A falling edge during TX is not latched.
- Counters: bit-period counter width is $clog2(BR). Bit-index counter is 4 bits. The timeout/turnaround counter is shared and saturates.

Optional Feature:
UART_SLV_ERRCNT_EN
- Defined: adds output err_cnt[7:0]. It increments on every err_parity or err_frame pulse, saturates at 0xFF, and resets to 0. A read of address 0x7F returns err_cnt instead of reg_rdata, with no reg_rd_en pulse.
- Undefined: no err_cnt port. Address 0x7F is an ordinary register.

Test Plan:
- BR=16: write frames 0x85, 0x3C (correct parity) → single reg_wr_en pulse with reg_addr=0x05, reg_wdata=0x3C; tx stays 1.
- Read frame 0x05, reg_rdata=0xA5 → reg_rd_en pulse with reg_addr=0x05. tx start bit 32 clocks after stop sample, bits 1,0,1,0,0,1,0,1 LSB first, parity 0, stop 1.
- Frame 0x85 with parity bit flipped → err_parity pulse; no reg_wr_en; FSM in IDLE; busy=0.
- rx low pulse of 4 clocks in IDLE → no frame, no error, busy returns 0 within BR clocks.
- Write address 0x85, then rx idle for 17 bit periods → err_frame pulse, no write. A following valid read is serviced normally.
- Assert rst_n low during TX_DATA → tx=1 immediately, busy=0. After release, a new write completes correctly.
